// File: rtl/mx_dot_pkg.sv
// Shared types and arithmetic for the MX dot-product engine.
// The accumulator mantissa width DPW is fixed here from the default K/BW.
package mx_dot_pkg;

   localparam int unsigned MX_K    = 32;
   localparam int unsigned MX_BW   = 8;
   localparam int unsigned SCALE_W = 12;

   // Width of a K-element block dot product of BW-bit signed ints
   function automatic int unsigned dpw_of(input int unsigned bw, input int unsigned k);
      return 2 * bw + $clog2(k);
   endfunction

   localparam int unsigned DPW = dpw_of(MX_BW, MX_K);

   typedef struct packed {
      logic signed [DPW-1:0]     m;
      logic        [SCALE_W-1:0] e;
   } mx_acc_t;

   // Align to the larger scale, add, and renormalise by one bit on overflow
   function automatic mx_acc_t norm_add(input mx_acc_t a, input mx_acc_t b);
      mx_acc_t              r;
      logic signed [DPW-1:0] big;
      logic signed [DPW-1:0] sml;
      logic [SCALE_W-1:0]    e;
      logic [SCALE_W-1:0]    diff;
      logic signed [DPW:0]   sum;
      if (a.e >= b.e) begin
         big  = a.m;
         sml  = b.m;
         e    = a.e;
         diff = a.e - b.e;
      end else begin
         big  = b.m;
         sml  = a.m;
         e    = b.e;
         diff = b.e - a.e;
      end
      // A shift of DPW-1 already leaves only the sign (0 or -1)
      if (diff >= SCALE_W'(DPW)) sml = sml >>> (DPW - 1);
      else                       sml = sml >>> diff;
      sum = {big[DPW-1], big} + {sml[DPW-1], sml};
      if (sum[DPW] != sum[DPW-1]) begin
         r.m = sum[DPW:1];
         r.e = e + SCALE_W'(1);
      end else begin
         r.m = sum[DPW-1:0];
         r.e = e;
      end
      return r;
   endfunction

endpackage

// File: rtl/mx_add_nrm_reg.sv
// Registered normalising adder with enable; one tree node or the accumulator.
module mx_add_nrm_reg
   import mx_dot_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    en,
   input  mx_acc_t a,
   input  mx_acc_t b,
   output mx_acc_t q
);

   // Sum register, held while the enable is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= norm_add(a, b);
   end

endmodule

// File: rtl/mx_dot_stream.sv
// Streaming MX dot-product engine: per-block int dot products, a registered
// normalising adder tree, a cross-beat accumulator and output normalisation.
// Optional NaN propagation of 8'hFF scales is built when MX_DOT_NAN_EN is defined.
module mx_dot_stream
   import mx_dot_pkg::*;
#(
   parameter int unsigned K         = MX_K,
   parameter int unsigned BW        = MX_BW,
   parameter int unsigned CH        = 8,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned MAX_BEATS = 256
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic                          i_last,
   input  logic [CH*K*BW-1:0]            i_x,
   input  logic [CH*K*BW-1:0]            i_y,
   input  logic [CH*8-1:0]               i_s,
   input  logic [CH*8-1:0]               i_t,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic signed [OUT_W-1:0]       o_dp,
   output logic [SCALE_W-1:0]            o_scale,
`ifdef MX_DOT_NAN_EN
   output logic                          o_nan,
`endif
   output logic [$clog2(MAX_BEATS):0]    o_beats
);

   localparam int unsigned LVLS    = $clog2(CH);
   localparam int unsigned NODES   = 2 * CH - 1;
   localparam int unsigned BEATS_W = $clog2(MAX_BEATS) + 1;

   logic run;
   assign run     = ~(o_valid & ~i_ready);
   assign o_ready = run;

   mx_acc_t blk_c [CH];
   mx_acc_t s0_q  [CH];
   mx_acc_t nd    [NODES];
   logic [LVLS:0] v_q;
   logic [LVLS:0] l_q;

   // Per-block integer dot product and combined block scale
   always_comb begin
      logic signed [BW-1:0]   xe;
      logic signed [BW-1:0]   ye;
      logic signed [2*BW-1:0] pr;
      logic signed [DPW-1:0]  dp;
      xe = '0;
      ye = '0;
      pr = '0;
      dp = '0;
      for (int b = 0; b < CH; b++) begin
         dp = '0;
         for (int k = 0; k < K; k++) begin
            xe = i_x[(b*K+k)*BW +: BW];
            ye = i_y[(b*K+k)*BW +: BW];
            pr = (2*BW)'(xe) * (2*BW)'(ye);
            dp = dp + DPW'(pr);
         end
         blk_c[b].m = dp;
         blk_c[b].e = SCALE_W'(i_s[b*8 +: 8]) + SCALE_W'(i_t[b*8 +: 8]);
      end
   end

   // Stage 0 block registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < CH; b++) s0_q[b] <= '0;
      end else if (run) begin
         for (int b = 0; b < CH; b++) s0_q[b] <= blk_c[b];
      end
   end

   // Beat valid/last travel alongside the tree
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q <= '0;
         l_q <= '0;
      end else if (run) begin
         v_q[0] <= i_valid;
         l_q[0] <= i_last;
         for (int unsigned i = 1; i <= LVLS; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
         end
      end
   end

   // Heap-ordered tree: leaves at CH-1.., node g sums children 2g+1 and 2g+2
   for (genvar g = 0; g < CH; g++) begin : g_leaf
      assign nd[CH-1+g] = s0_q[g];
   end
   for (genvar g = 0; g < CH - 1; g++) begin : g_node
      mx_add_nrm_reg u_add (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .en    (run),
         .a     (nd[2*g+1]),
         .b     (nd[2*g+2]),
         .q     (nd[g])
      );
   end

   logic                open_q;
   logic                fin_q;
   logic [BEATS_W-1:0]  beats_q;
   logic [BEATS_W-1:0]  beats_nx;
   logic                first;
   logic                term;
   mx_acc_t             acc_b;
   mx_acc_t             acc_q;

   assign first    = ~open_q;
   assign beats_nx = first ? BEATS_W'(1) : beats_q + BEATS_W'(1);
   assign term     = l_q[LVLS] | (beats_nx == BEATS_W'(MAX_BEATS));

   // Adding to zero on the first beat loads the tree result unchanged
   always_comb begin
      acc_b = acc_q;
      if (first) acc_b = '0;
   end

   mx_add_nrm_reg u_acc (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (run & v_q[LVLS]),
      .a     (nd[0]),
      .b     (acc_b),
      .q     (acc_q)
   );

   // Vector bookkeeping: beat count, open vector, finished flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         open_q  <= 1'b0;
         fin_q   <= 1'b0;
         beats_q <= '0;
      end else if (run) begin
         fin_q <= v_q[LVLS] & term;
         if (v_q[LVLS]) begin
            beats_q <= beats_nx;
            open_q  <= ~term;
         end
      end
   end

`ifdef MX_DOT_NAN_EN
   logic          nan_c;
   logic [LVLS:0] n_q;
   logic          nan_q;

   // Any all-ones block scale poisons the beat
   always_comb begin
      nan_c = 1'b0;
      for (int b = 0; b < CH; b++)
         nan_c = nan_c | (i_s[b*8 +: 8] == 8'hFF) | (i_t[b*8 +: 8] == 8'hFF);
   end

   // NaN mark follows the beat through the tree and sticks for the vector
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         n_q   <= '0;
         nan_q <= 1'b0;
      end else if (run) begin
         n_q[0] <= i_valid & nan_c;
         for (int unsigned i = 1; i <= LVLS; i++) n_q[i] <= n_q[i-1];
         if (v_q[LVLS]) nan_q <= (nan_q & ~first) | n_q[LVLS];
      end
   end
`endif

   logic signed [DPW-1:0]   am;
   logic signed [DPW-1:0]   sh;
   logic                    found;
   logic signed [OUT_W-1:0] nrm_dp_c;
   logic [SCALE_W-1:0]      nrm_sc_c;

   // Smallest right shift that makes the accumulator fit OUT_W signed
   always_comb begin
      am       = acc_q.m;
      sh       = '0;
      found    = 1'b0;
      nrm_dp_c = OUT_W'(am >>> (DPW - OUT_W));
      nrm_sc_c = acc_q.e + SCALE_W'(DPW - OUT_W);
      for (int unsigned n = 0; n <= DPW - OUT_W; n++) begin
         sh = am >>> n;
         if (!found && ((&sh[DPW-1:OUT_W-1]) || !(|sh[DPW-1:OUT_W-1]))) begin
            found    = 1'b1;
            nrm_dp_c = sh[OUT_W-1:0];
            nrm_sc_c = acc_q.e + SCALE_W'(n);
         end
      end
   end

   // Output register, frozen while the consumer stalls
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_dp    <= '0;
         o_scale <= '0;
         o_beats <= '0;
`ifdef MX_DOT_NAN_EN
         o_nan   <= 1'b0;
`endif
      end else if (run) begin
         o_valid <= fin_q;
         if (fin_q) begin
            o_dp    <= nrm_dp_c;
            o_scale <= nrm_sc_c;
            o_beats <= beats_q;
`ifdef MX_DOT_NAN_EN
            o_nan   <= nan_q;
            if (nan_q) begin
               o_dp    <= '0;
               o_scale <= '1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_mx_dot_stream.sv
// Directed bench for mx_dot_stream with a result scoreboard.
// Builds with or without MX_DOT_NAN_EN.
module tb_mx_dot_stream;

   localparam int unsigned K = 32, BW = 8, CH = 8, OUT_W = 8, MAX_BEATS = 256;

   logic                    clk;
   logic                    rst_n;
   logic                    i_valid, i_last, i_ready;
   logic                    o_ready, o_valid;
   logic [CH*K*BW-1:0]      x, y;
   logic [CH*8-1:0]         s, t;
   logic signed [OUT_W-1:0] o_dp;
   logic [11:0]             o_scale;
   logic [8:0]              o_beats;
`ifdef MX_DOT_NAN_EN
   logic                    o_nan;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int cap_dp[$], cap_sc[$], cap_bt[$], cap_cy[$];
   int exp_dp[$], exp_sc[$], exp_bt[$];

   // Expected single-beat results per data pattern id
   int edp[7] = '{64, 32, 64, -128, 64, 64, 72};
   int esc[7] = '{2, 0, 10, 1, 16, 1, 2};

   mx_dot_stream #(.K(K), .BW(BW), .CH(CH), .OUT_W(OUT_W), .MAX_BEATS(MAX_BEATS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_last  (i_last),
      .i_x     (x),
      .i_y     (y),
      .i_s     (s),
      .i_t     (t),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_dp    (o_dp),
      .o_scale (o_scale),
`ifdef MX_DOT_NAN_EN
      .o_nan   (o_nan),
`endif
      .o_beats (o_beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Record every result transfer
   always @(negedge clk) begin
      if (rst_n && o_valid && i_ready) begin
         cap_dp.push_back(int'(o_dp));
         cap_sc.push_back(int'(o_scale));
         cap_bt.push_back(int'(o_beats));
         cap_cy.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic set_blk(input int b, input logic [7:0] xv, input logic [7:0] yv,
                          input logic [7:0] sv, input logic [7:0] tv);
      for (int k = 0; k < K; k++) begin
         x[(b*K+k)*BW +: BW] = xv;
         y[(b*K+k)*BW +: BW] = yv;
      end
      s[b*8 +: 8] = sv;
      t[b*8 +: 8] = tv;
   endtask

   task automatic set_all(input logic [7:0] xv, input logic [7:0] yv);
      for (int b = 0; b < CH; b++) set_blk(b, xv, yv, 8'd0, 8'd0);
   endtask

   task automatic load(input int id);
      case (id)
         0: set_all(8'd1, 8'd1);
         1: begin set_all(8'd0, 8'd0); set_blk(0, 8'd1, 8'd1, 8'd0, 8'd0); end
         2: begin set_all(8'd0, 8'd0); set_blk(0, 8'd2, 8'd1, 8'd4, 8'd6);
                  set_blk(1, 8'd1, 8'd1, 8'd0, 8'd0); end
         3: set_all(8'hFF, 8'd1);
         4: set_all(8'h80, 8'h80);
         5: begin set_all(8'd0, 8'd0); set_blk(0, 8'd2, 8'd2, 8'd0, 8'd0); end
         default: begin set_all(8'd1, 8'd1); set_blk(0, 8'd1, 8'd1, 8'd1, 8'd0); end
      endcase
   endtask

   task automatic send(input bit last);
      bit ok;
      int n;
      n = 0;
      i_valid = 1'b1;
      i_last  = last;
      do begin
         ok = o_ready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) chk("send_accept", 0, 1);
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic push_exp(input int dp, input int sc, input int bt);
      exp_dp.push_back(dp);
      exp_sc.push_back(sc);
      exp_bt.push_back(bt);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (cap_dp.size() < exp_dp.size() && n < 100) begin idle(1); n++; end
      idle(8);
      chk({tag, "_count"}, cap_dp.size(), exp_dp.size());
      for (int i = 0; i < exp_dp.size() && i < cap_dp.size(); i++) begin
         chk($sformatf("%s_dp%0d", tag, i), cap_dp[i], exp_dp[i]);
         chk($sformatf("%s_scale%0d", tag, i), cap_sc[i], exp_sc[i]);
         chk($sformatf("%s_beats%0d", tag, i), cap_bt[i], exp_bt[i]);
      end
      cap_dp.delete(); cap_sc.delete(); cap_bt.delete(); cap_cy.delete();
      exp_dp.delete(); exp_sc.delete(); exp_bt.delete();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
      x = '0; y = '0; s = '0; t = '0;
      idle(3);
      chk("rst_valid", o_valid, 0);
      chk("rst_dp", o_dp, 0);
      chk("rst_scale", o_scale, 0);
      chk("rst_beats", o_beats, 0);
      chk("rst_ready", o_ready, 1);
      rst_n = 1'b1;
      idle(2);

      // Latency of a single-beat vector
      load(0);
      send(1);
      n = 0;
      while (!o_valid && n < 20) begin idle(1); n++; end
      chk("latency", n, 5);
      push_exp(64, 2, 1);
      drain("lat");

      // Single-beat patterns
      for (int id = 0; id < 7; id++) begin
         load(id);
         send(1);
         push_exp(edp[id], esc[id], 1);
         drain($sformatf("pat%0d", id));
      end

      // Three beats, 768 accumulated
      load(0);
      send(0); send(0); send(1);
      push_exp(96, 3, 3);
      drain("multi");

      // Bubble between beats leaves the accumulator alone
      load(0);
      send(0); idle(3); send(1);
      push_exp(64, 3, 2);
      drain("bubble");

      // Forced termination at MAX_BEATS, then a fresh vector
      load(1);
      repeat (MAX_BEATS) send(0);
      load(0);
      send(1);
      push_exp(64, 7, 256);
      push_exp(64, 2, 1);
      drain("maxbeats");

      // Back-to-back last beats give results on consecutive cycles
      load(0); send(1);
      load(3); send(1);
      load(6); send(1);
      push_exp(64, 2, 1); push_exp(-128, 1, 1); push_exp(72, 2, 1);
      n = 0;
      while (cap_cy.size() < 3 && n < 50) begin idle(1); n++; end
      chk("b2b_seen", cap_cy.size() >= 3, 1);
      if (cap_cy.size() >= 3) begin
         chk("b2b_gap1", cap_cy[1] - cap_cy[0], 1);
         chk("b2b_gap2", cap_cy[2] - cap_cy[1], 1);
      end
      drain("b2b");

      // Consumer stalls for four cycles with results pending
      i_ready = 1'b0;
      load(0); send(1);
      load(3); send(1);
      load(6); send(1);
      n = 0;
      while (!o_valid && n < 20) begin idle(1); n++; end
      chk("stall_valid", o_valid, 1);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("stall_ready%0d", c), o_ready, 0);
         chk($sformatf("stall_dp%0d", c), o_dp, 64);
         chk($sformatf("stall_scale%0d", c), o_scale, 2);
         chk($sformatf("stall_beats%0d", c), o_beats, 1);
         idle(1);
      end
      i_ready = 1'b1;
      push_exp(64, 2, 1); push_exp(-128, 1, 1); push_exp(72, 2, 1);
      drain("stall");

      // Reset mid-vector with a result waiting
      i_ready = 1'b0;
      load(0);
      send(1); send(0); send(0);
      n = 0;
      while (!o_valid && n < 20) begin idle(1); n++; end
      chk("prerst_valid", o_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", o_valid, 0);
      chk("midrst_dp", o_dp, 0);
      chk("midrst_scale", o_scale, 0);
      chk("midrst_beats", o_beats, 0);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      i_ready = 1'b1;
      load(0);
      send(1);
      push_exp(64, 2, 1);
      drain("postrst");

`ifdef MX_DOT_NAN_EN
      // NaN vector, then the mark clears for the next vector
      load(0); set_blk(3, 8'd1, 8'd1, 8'hFF, 8'd0);
      send(1);
      push_exp(0, 4095, 1);
      load(0);
      send(1);
      push_exp(64, 2, 1);
      drain("nan");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
